// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the attached keyboard using the host-initiated
// protocol: request-to-send (clock held low), start bit, eight data bits LSB
// first, odd parity, stop bit, then the device ACK. Both lines are driven
// open-drain: the block only asserts "pull low" requests, and the top level
// turns them into tristate buffers shared with the PS/2 receive port.
// rx_en gates the receiver off for the whole transmit.
// FILTER_LEN must be at least 1; TIMEOUT_CYCLES and RTS_CYCLES at least 1.
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 10000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_drv_low,
    output logic       ps2d_drv_low,
    output logic       rx_en,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    // One timer serves both the request-to-send hold and the edge timeout,
    // so it is sized for whichever of the two is longer.
    localparam int TIMER_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] RTS_LAST  = TW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        WAIT_REL
    } state_t;

    // ------------------------------------------------------------------
    // ps2c glitch filter and falling-edge detector
    // ------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filt_reg;
    logic [FILTER_LEN-1:0] filt_shift;
    logic [FILTER_LEN:0]   filt_cat;
    logic                  f_ps2c_reg;
    logic                  f_ps2c_next;
    logic                  fall_edge;

    // Shift the newest ps2c sample in at the top; the filtered level only
    // moves once every sample in the window agrees.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        filt_cat    = {ps2c_in, filt_reg};
        filt_shift  = filt_cat[FILTER_LEN:1];
        f_ps2c_next = f_ps2c_reg;
        if (filt_reg == {FILTER_LEN{1'b1}}) begin
            f_ps2c_next = 1'b1;
        end else if (filt_reg == {FILTER_LEN{1'b0}}) begin
            f_ps2c_next = 1'b0;
        end
    end

    // Filter window and filtered level; both start at the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register sees the pre-edge values of the others.
        if (!reset) begin
            filt_reg   <= {FILTER_LEN{1'b1}};
            f_ps2c_reg <= 1'b1;
        end else begin
            filt_reg   <= filt_shift;
            f_ps2c_reg <= f_ps2c_next;
        end
    end

    // One-cycle pulse on a filtered high-to-low transition of the device clock.
    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [TW-1:0]   t_reg, t_next;
    logic [3:0]      n_reg, n_next;
    logic [8:0]      sr_reg, sr_next;
    logic            c_drv_reg, c_drv_next;
    logic            d_drv_reg, d_drv_next;
    logic            timed_out;

    // State, timer, bit counter, shift register and registered line drivers.
    // A reset in mid-frame releases both lines at once and abandons the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            t_reg     <= '0;
            n_reg     <= '0;
            sr_reg    <= '0;
            c_drv_reg <= 1'b0;
            d_drv_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            n_reg     <= n_next;
            sr_reg    <= sr_next;
            c_drv_reg <= c_drv_next;
            d_drv_reg <= d_drv_next;
        end
    end

    assign timed_out = (t_reg == TIMEOUT_T);

    // Next-state logic: line drivers change on the filtered falling edge so the
    // device samples stable data on its following rising edge.
    always_comb begin
        state_next   = state_reg;
        t_next       = t_reg;
        n_next       = n_reg;
        sr_next      = sr_reg;
        c_drv_next   = c_drv_reg;
        d_drv_next   = d_drv_reg;
        tx_idle      = 1'b0;
        rx_en        = 1'b0;
        tx_done_tick = 1'b0;
        tx_err_tick  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                tx_idle    = 1'b1;
                rx_en      = 1'b1;
                c_drv_next = 1'b0;
                d_drv_next = 1'b0;
                if (wr_ps2) begin
                    // Odd parity: parity bit is 1 when din has an even count of 1s.
                    sr_next    = {~^din, din};
                    t_next     = '0;
                    n_next     = '0;
                    c_drv_next = 1'b1;
                    state_next = RTS;
                end
            end

            RTS: begin
                // Clock held low for exactly RTS_CYCLES cycles, then the start
                // bit goes out on the data line as the clock is released.
                if (t_reg == RTS_LAST) begin
                    c_drv_next = 1'b0;
                    d_drv_next = 1'b1;
                    t_next     = '0;
                    state_next = START;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end

            START: begin
                if (fall_edge) begin
                    d_drv_next = ~sr_reg[0];
                    sr_next    = {1'b0, sr_reg[8:1]};
                    n_next     = 4'd1;
                    t_next     = '0;
                    state_next = DATA;
                end else if (timed_out) begin
                    c_drv_next  = 1'b0;
                    d_drv_next  = 1'b0;
                    tx_err_tick = 1'b1;
                    state_next  = IDLE;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end

            DATA: begin
                if (fall_edge) begin
                    t_next = '0;
                    if (n_reg == 4'd9) begin
                        // Data and parity are out; release for the stop bit.
                        d_drv_next = 1'b0;
                        state_next = STOP;
                    end else begin
                        d_drv_next = ~sr_reg[0];
                        sr_next    = {1'b0, sr_reg[8:1]};
                        n_next     = n_reg + 4'd1;
                    end
                end else if (timed_out) begin
                    c_drv_next  = 1'b0;
                    d_drv_next  = 1'b0;
                    tx_err_tick = 1'b1;
                    state_next  = IDLE;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end

            STOP: begin
                if (fall_edge) begin
                    t_next = '0;
                    if (!ps2d_in) begin
                        state_next = WAIT_REL;
                    end else begin
                        // Device did not pull data low: no acknowledge.
                        tx_err_tick = 1'b1;
                        state_next  = IDLE;
                    end
                end else if (timed_out) begin
                    c_drv_next  = 1'b0;
                    d_drv_next  = 1'b0;
                    tx_err_tick = 1'b1;
                    state_next  = IDLE;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end

            WAIT_REL: begin
                // Wait for the device to let go of both lines after its ACK.
                if (f_ps2c_reg && ps2d_in) begin
                    tx_done_tick = 1'b1;
                    state_next   = IDLE;
                end else if (timed_out) begin
                    c_drv_next  = 1'b0;
                    d_drv_next  = 1'b0;
                    tx_err_tick = 1'b1;
                    state_next  = IDLE;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end

            default: begin
                c_drv_next = 1'b0;
                d_drv_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign ps2c_drv_low = c_drv_reg;
    assign ps2d_drv_low = d_drv_reg;

endmodule
